// File: rtl/pi_seq_pkg.sv
// Shared types for the PI-compensation ALU sequencer: FSM states, ALU source
// selects and the control word driven to the ALU.
package pi_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWaitA2d,
        StErr,
        StIntg,
        StIcmp,
        StPcmp,
        StAcc,
        StOut,
        StDone
    } state_e;

    localparam logic [2:0] SRC1_ACCUM    = 3'b000;
    localparam logic [2:0] SRC1_ITERM    = 3'b001;
    localparam logic [2:0] SRC1_ERROR    = 3'b010;
    localparam logic [2:0] SRC1_ERRDIV16 = 3'b011;
    localparam logic [2:0] SRC1_FWD      = 3'b100;

    localparam logic [2:0] SRC0_A2D      = 3'b000;
    localparam logic [2:0] SRC0_INTGRL   = 3'b001;
    localparam logic [2:0] SRC0_ICOMP    = 3'b010;
    localparam logic [2:0] SRC0_PCOMP    = 3'b011;
    localparam logic [2:0] SRC0_PTERM    = 3'b100;

    typedef struct packed {
        logic [2:0] src1sel;
        logic [2:0] src0sel;
        logic       multiply;
        logic       saturate;
        logic       sub;
        logic       mult2;
        logic       mult4;
    } ctrl_t;

    localparam ctrl_t CtrlNop = '0;

    // mult2/mult4 are never used by this sequence, so they are tied low here.
    function automatic ctrl_t mk_ctrl(input logic [2:0] s1, input logic [2:0] s0,
                                      input logic mul, input logic sat, input logic sb);
        ctrl_t c;
        c          = CtrlNop;
        c.src1sel  = s1;
        c.src0sel  = s0;
        c.multiply = mul;
        c.saturate = sat;
        c.sub      = sb;
        return c;
    endfunction

endpackage

// File: rtl/pi_alu_sequencer_if.sv
// Bundle of the sequencer's handshake and ALU-facing signals.
// The master modport is the sequencer; slave is the A2D/ALU side.
interface pi_alu_sequencer_if #(
    parameter int unsigned DW = 16
) ();
    logic          go;
    logic          cnv_cmplt;
    logic [11:0]   a2d_res;
    logic [DW-1:0] dst;

    logic          strt_cnv;
    logic [2:0]    src1sel;
    logic [2:0]    src0sel;
    logic          multiply;
    logic          saturate;
    logic          sub;
    logic          mult2;
    logic          mult4;
    logic [DW-1:0] Accum;
    logic [DW-1:0] Pcomp;
    logic [DW-1:0] Error;
    logic [DW-1:0] Intgrl;
    logic [DW-1:0] Icomp;
    logic [DW-1:0] a2d_val;
    logic [DW-1:0] mtr_out;
    logic          busy;
    logic          done;
    logic          tmo_err;

    modport master (
        input  go, cnv_cmplt, a2d_res, dst,
        output strt_cnv, src1sel, src0sel, multiply, saturate, sub, mult2, mult4,
        output Accum, Pcomp, Error, Intgrl, Icomp, a2d_val, mtr_out, busy, done, tmo_err
    );

    modport slave (
        output go, cnv_cmplt, a2d_res, dst,
        input  strt_cnv, src1sel, src0sel, multiply, saturate, sub, mult2, mult4,
        input  Accum, Pcomp, Error, Intgrl, Icomp, a2d_val, mtr_out, busy, done, tmo_err
    );

endinterface

// File: rtl/pi_seq_decode.sv
// Pure state -> ALU control word decode; non-compute states emit an all-zero word.
module pi_seq_decode
    import pi_seq_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = CtrlNop;
        case (state_i)
            StErr:   ctrl_o = mk_ctrl(SRC1_FWD,      SRC0_A2D,    1'b0, 1'b1, 1'b1);
            StIntg:  ctrl_o = mk_ctrl(SRC1_ERRDIV16, SRC0_INTGRL, 1'b0, 1'b1, 1'b0);
            StIcmp:  ctrl_o = mk_ctrl(SRC1_ITERM,    SRC0_INTGRL, 1'b1, 1'b0, 1'b0);
            StPcmp:  ctrl_o = mk_ctrl(SRC1_ERROR,    SRC0_PTERM,  1'b1, 1'b0, 1'b0);
            StAcc:   ctrl_o = mk_ctrl(SRC1_FWD,      SRC0_PCOMP,  1'b0, 1'b1, 1'b0);
            StOut:   ctrl_o = mk_ctrl(SRC1_ACCUM,    SRC0_ICOMP,  1'b0, 1'b1, 1'b0);
            default: ctrl_o = CtrlNop;
        endcase
    end

endmodule

// File: rtl/pi_alu_sequencer.sv
// PI-compensation sequencer: one A2D conversion per go, then six ALU ops whose results
// land in the operand registers. Optional macro INTGRL_DECIMATE_EN updates Intgrl every 4th run.
module pi_alu_sequencer
    import pi_seq_pkg::*;
#(
    parameter int unsigned A2D_TMO = 1023,
    parameter int unsigned DW      = 16
) (
    input logic               clk,
    input logic               rst_n,
    pi_alu_sequencer_if.master bus
);

    localparam int unsigned     CntW   = $clog2(A2D_TMO + 1);
    localparam logic [CntW-1:0] TmoVal = CntW'(A2D_TMO);

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          strt_cnv_q, strt_cnv_d;
    logic          done_q, done_d;
    logic          tmo_err_q, tmo_err_d;
    logic [DW-1:0] accum_q, accum_d;
    logic [DW-1:0] pcomp_q, pcomp_d;
    logic [DW-1:0] error_q, error_d;
    logic [DW-1:0] intgrl_q, intgrl_d;
    logic [DW-1:0] icomp_q, icomp_d;
    logic [DW-1:0] a2d_val_q, a2d_val_d;
    logic [DW-1:0] mtr_out_q, mtr_out_d;
    logic          intgrl_we;
    ctrl_t         ctrl;

`ifdef INTGRL_DECIMATE_EN
    logic [1:0] dec_cnt_q, dec_cnt_d;

    assign intgrl_we = (dec_cnt_q == 2'd3);
    assign dec_cnt_d = (state_q == StDone) ? dec_cnt_q + 2'd1 : dec_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt_q <= 2'd0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
        end
    end
`else
    assign intgrl_we = 1'b1;
`endif

    pi_seq_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        strt_cnv_d = 1'b0;
        done_d     = 1'b0;
        tmo_err_d  = tmo_err_q;
        accum_d    = accum_q;
        pcomp_d    = pcomp_q;
        error_d    = error_q;
        intgrl_d   = intgrl_q;
        icomp_d    = icomp_q;
        a2d_val_d  = a2d_val_q;
        mtr_out_d  = mtr_out_q;

        case (state_q)
            StIdle: begin
                if (bus.go) begin
                    state_d    = StWaitA2d;
                    strt_cnv_d = 1'b1;
                    cnt_d      = '0;
                    tmo_err_d  = 1'b0;
                end
            end
            StWaitA2d: begin
                // A completion arriving on the timeout cycle still counts as success.
                if (bus.cnv_cmplt) begin
                    a2d_val_d = DW'(bus.a2d_res);
                    state_d   = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_d == TmoVal) begin
                        tmo_err_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StErr: begin
                error_d = bus.dst;
                state_d = StIntg;
            end
            StIntg: begin
                if (intgrl_we) begin
                    intgrl_d = bus.dst;
                end
                state_d = StIcmp;
            end
            StIcmp: begin
                icomp_d = bus.dst;
                state_d = StPcmp;
            end
            StPcmp: begin
                pcomp_d = bus.dst;
                state_d = StAcc;
            end
            StAcc: begin
                accum_d = bus.dst;
                state_d = StOut;
            end
            StOut: begin
                mtr_out_d = bus.dst;
                done_d    = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            strt_cnv_q <= 1'b0;
            done_q     <= 1'b0;
            tmo_err_q  <= 1'b0;
            accum_q    <= '0;
            pcomp_q    <= '0;
            error_q    <= '0;
            intgrl_q   <= '0;
            icomp_q    <= '0;
            a2d_val_q  <= '0;
            mtr_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            strt_cnv_q <= strt_cnv_d;
            done_q     <= done_d;
            tmo_err_q  <= tmo_err_d;
            accum_q    <= accum_d;
            pcomp_q    <= pcomp_d;
            error_q    <= error_d;
            intgrl_q   <= intgrl_d;
            icomp_q    <= icomp_d;
            a2d_val_q  <= a2d_val_d;
            mtr_out_q  <= mtr_out_d;
        end
    end

    assign bus.strt_cnv = strt_cnv_q;
    assign bus.src1sel  = ctrl.src1sel;
    assign bus.src0sel  = ctrl.src0sel;
    assign bus.multiply = ctrl.multiply;
    assign bus.saturate = ctrl.saturate;
    assign bus.sub      = ctrl.sub;
    assign bus.mult2    = ctrl.mult2;
    assign bus.mult4    = ctrl.mult4;
    assign bus.Accum    = accum_q;
    assign bus.Pcomp    = pcomp_q;
    assign bus.Error    = error_q;
    assign bus.Intgrl   = intgrl_q;
    assign bus.Icomp    = icomp_q;
    assign bus.a2d_val  = a2d_val_q;
    assign bus.mtr_out  = mtr_out_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_pi_alu_sequencer.sv
// Self-checking bench for pi_alu_sequencer: table of per-op control words and ALU results,
// plus directed reset/timeout/boundary sequences and randomized iterations vs a register model.
module tb_pi_alu_sequencer;

    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 1023;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pi_alu_sequencer_if #(.DW(DW)) bus ();

    pi_alu_sequencer #(.A2D_TMO(TMO), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // flags packed as {multiply, saturate, sub, mult2, mult4}
    typedef struct {
        logic [15:0] dst;
        logic [2:0]  s1;
        logic [2:0]  s0;
        logic [4:0]  fl;
    } step_t;

    step_t tbl[6];

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model: register contents after each completed iteration.
    logic [15:0] m_a2d, m_err, m_intgrl, m_icomp, m_pcomp, m_acc, m_mtr;
    logic        m_tmo;
    int unsigned m_iters;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_a2d = '0; m_err = '0; m_intgrl = '0; m_icomp = '0;
        m_pcomp = '0; m_acc = '0; m_mtr = '0; m_tmo = 1'b0; m_iters = 0;
    endtask

    function automatic logic [10:0] ctrl_word();
        return {bus.src1sel, bus.src0sel, bus.multiply, bus.saturate, bus.sub,
                bus.mult2, bus.mult4};
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, "_a2d_val"}, bus.a2d_val, m_a2d);
        chk({tag, "_Error"},   bus.Error,   m_err);
        chk({tag, "_Intgrl"},  bus.Intgrl,  m_intgrl);
        chk({tag, "_Icomp"},   bus.Icomp,   m_icomp);
        chk({tag, "_Pcomp"},   bus.Pcomp,   m_pcomp);
        chk({tag, "_Accum"},   bus.Accum,   m_acc);
        chk({tag, "_mtr_out"}, bus.mtr_out, m_mtr);
        chk({tag, "_tmo_err"}, bus.tmo_err, m_tmo);
    endtask

    // One full iteration; dst values come from tbl[].dst.
    task automatic run_iter(input string tag, input logic [11:0] res, input int unsigned wcyc,
                            input logic hold, input logic noise);
        logic intg_wr;
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
        bus.go = 1'b1;
        tick();
        chk({tag, "_strt_pulse"}, bus.strt_cnv, 1'b1);
        chk({tag, "_wait_busy"}, bus.busy, 1'b1);
        chk({tag, "_tmo_clr"}, bus.tmo_err, 1'b0);
        chk({tag, "_wait_ctrl"}, ctrl_word(), 11'd0);
        if (!hold) bus.go = 1'b0;
        for (int k = 0; k < int'(wcyc); k++) begin
            tick();
            chk({tag, "_strt_once"}, bus.strt_cnv, 1'b0);
            chk({tag, "_wait_busy"}, bus.busy, 1'b1);
        end
        bus.cnv_cmplt = 1'b1;
        bus.a2d_res   = res;
        tick();
        bus.cnv_cmplt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.dst = tbl[i].dst;
            if (noise) begin
                bus.cnv_cmplt = 1'($urandom_range(0, 1));
                bus.a2d_res   = 12'($urandom);
            end
            chk($sformatf("%s_ctrl%0d", tag, i), ctrl_word(), {tbl[i].s1, tbl[i].s0, tbl[i].fl});
            chk($sformatf("%s_nodone%0d", tag, i), bus.done, 1'b0);
            chk($sformatf("%s_nostrt%0d", tag, i), bus.strt_cnv, 1'b0);
            tick();
        end
        bus.cnv_cmplt = 1'b0;
        bus.go        = 1'b0;

`ifdef INTGRL_DECIMATE_EN
        intg_wr = ((m_iters % 4) == 3);
`else
        intg_wr = 1'b1;
`endif
        m_a2d = {4'b0, res};
        m_err = tbl[0].dst;
        if (intg_wr) m_intgrl = tbl[1].dst;
        m_icomp = tbl[2].dst;
        m_pcomp = tbl[3].dst;
        m_acc   = tbl[4].dst;
        m_mtr   = tbl[5].dst;
        m_tmo   = 1'b0;
        m_iters++;

        chk({tag, "_done_pulse"}, bus.done, 1'b1);
        chk({tag, "_done_busy"}, bus.busy, 1'b1);
        chk({tag, "_done_ctrl"}, ctrl_word(), 11'd0);
        chk_regs(tag);
        tick();
        chk({tag, "_done_fall"}, bus.done, 1'b0);
        chk({tag, "_end_busy"}, bus.busy, 1'b0);
        chk({tag, "_end_strt"}, bus.strt_cnv, 1'b0);
    endtask

    task automatic set_dst(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                           input logic [15:0] d3, input logic [15:0] d4, input logic [15:0] d5);
        tbl[0].dst = d0; tbl[1].dst = d1; tbl[2].dst = d2;
        tbl[3].dst = d3; tbl[4].dst = d4; tbl[5].dst = d5;
    endtask

    initial begin
        tbl[0] = '{16'h0, 3'b100, 3'b000, 5'b01100};
        tbl[1] = '{16'h0, 3'b011, 3'b001, 5'b01000};
        tbl[2] = '{16'h0, 3'b001, 3'b001, 5'b10000};
        tbl[3] = '{16'h0, 3'b010, 3'b100, 5'b10000};
        tbl[4] = '{16'h0, 3'b100, 3'b011, 5'b01000};
        tbl[5] = '{16'h0, 3'b000, 3'b010, 5'b01000};

        bus.go = 1'b0; bus.cnv_cmplt = 1'b0; bus.a2d_res = '0; bus.dst = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_clear();
        chk_regs("rst");
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_strt", bus.strt_cnv, 1'b0);
        chk("rst_ctrl", ctrl_word(), 11'd0);

        set_dst(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        run_iter("basic", 12'hABC, 5, 1'b0, 1'b0);

        // Reset while in PCMP
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        bus.cnv_cmplt = 1'b1; bus.a2d_res = 12'h123;
        tick();
        bus.cnv_cmplt = 1'b0; bus.dst = 16'hBEEF;
        tick(); tick(); tick();
        chk("pcmp_src1", bus.src1sel, 3'b010);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk_regs("midrst");
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_strt", bus.strt_cnv, 1'b0);
        chk("midrst_ctrl", ctrl_word(), 11'd0);
        tick();
        chk("midrst_idle", bus.busy, 1'b0);
        chk_regs("midrst2");

        set_dst(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0F0F);
        run_iter("refill", 12'h5A5, 0, 1'b0, 1'b0);

        // Conversion never completes
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        repeat (TMO - 1) tick();
        chk("tmo_still_busy", bus.busy, 1'b1);
        chk("tmo_not_yet", bus.tmo_err, 1'b0);
        tick();
        m_tmo = 1'b1;
        chk("tmo_busy", bus.busy, 1'b0);
        chk_regs("tmo");
        tick();
        chk("tmo_sticky", bus.tmo_err, 1'b1);

        // Completion on the timeout cycle wins; also clears the sticky flag
        set_dst(16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789);
        run_iter("tmo_edge", 12'hFFF, TMO - 1, 1'b0, 1'b0);

        set_dst(16'hCAFE, 16'h0007, 16'hF00D, 16'h8001, 16'h7FFF, 16'h0001);
        run_iter("hold_noise", 12'h001, 3, 1'b1, 1'b1);

        for (int it = 0; it < 8; it++) begin
            set_dst(16'($urandom), 16'h0007 + 16'(it), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom));
            run_iter($sformatf("rnd%0d", it), 12'($urandom), $urandom_range(0, 20),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pi_alu_sequencer.md
Name: pi_alu_sequencer

Overview:
- Control-and-register stage directly upstream of the datapath ALU.
- On each `go`, requests one A2D conversion and waits for it to complete.
- Then steps the ALU through a fixed six-operation PI-compensation sequence, one op per cycle, capturing the ALU `dst` result into internal operand registers.
- Operand registers (`Accum`, `Pcomp`, `Error`, `Intgrl`, `Icomp`) feed back to the ALU; the final result is presented as `mtr_out` with a one-cycle `done` pulse.

Parameters:
- A2D_TMO, 1023, max cycles waited for `cnv_cmplt` before abort (timeout counter width = clog2(A2D_TMO+1)).
- DW, 16, datapath / register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- go  input  1  start one control iteration (level; sampled only in IDLE).
- cnv_cmplt  input  1  A2D conversion-complete strobe.
- a2d_res  input  12  A2D result, valid when cnv_cmplt=1.
- dst  input  DW  ALU result for the current control word.
- strt_cnv  output  1  one-cycle conversion request to A2D.
- src1sel  output  3  ALU src1 mux select.
- src0sel  output  3  ALU src0 mux select.
- multiply, saturate, sub, mult2, mult4  output  1 each  ALU op flags.
- Accum, Pcomp, Error, Intgrl, Icomp  output  DW each  operand registers to ALU.
- a2d_val  output  DW  captured conversion, zero-extended.
- mtr_out  output  DW  final compensated output.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- tmo_err  output  1  sticky A2D timeout flag; cleared on next accepted `go`.

Behaviour:
- Reset (synchronous, rst_n=0 at a rising edge): state=IDLE; all registers and outputs 0, including the control word; takes effect even mid-sequence; the in-flight op is discarded.
- States: IDLE, WAIT_A2D, ERR, INTG, ICMP, PCMP, ACC, OUT, DONE.
- IDLE: go=1 → WAIT_A2D; strt_cnv=1 for exactly one cycle (registered); timeout counter cleared; tmo_err cleared.
- WAIT_A2D:
  - cnv_cmplt=1 → a2d_val<= {4'b0,a2d_res}; → ERR.
  - Else counter++; counter==A2D_TMO → tmo_err<=1, → IDLE; registers untouched.
  - cnv_cmplt and timeout in the same cycle: cnv_cmplt wins.
- Compute states each drive one control word combinationally from state. The table gives {src1sel,src0sel,flags} → destination written with dst at the closing edge:
  - ERR: {100,000,sub+saturate} → Error
  - INTG: {011,001,saturate} → Intgrl
  - ICMP: {001,001,multiply} → Icomp
  - PCMP: {010,100,multiply} → Pcomp
  - ACC: {100,011,saturate} → Accum
  - OUT: {000,010,saturate} → mtr_out
- Non-compute states: src selects 000, all flags 0; no register writes.
- mult2 and mult4 are always 0 in this sequence; the ports exist for ALU compatibility.
- DONE: done=1 for one cycle → IDLE. done rises 6 clock edges after the edge sampling cnv_cmplt=1.
- go during busy: ignored, not queued. cnv_cmplt outside WAIT_A2D: ignored.
- Registers retain values between iterations (Intgrl accumulates across runs).

Optional Feature:
- Macro INTGRL_DECIMATE_EN.
- Defined:
  - A 2-bit decimation counter increments on each DONE.
  - INTG writes Intgrl only when counter==3; otherwise INTG still occurs (same control word, same cycle count) but the Intgrl write is suppressed.
  - Counter resets to 0.
- Undefined: Intgrl is written every iteration; no counter exists.

Decomposition:
- Package pi_seq_pkg: state enum; SRC1_ACCUM=000, SRC1_ITERM=001, SRC1_ERROR=010, SRC1_ERRDIV16=011, SRC1_FWD=100; SRC0_A2D=000, SRC0_INTGRL=001, SRC0_ICOMP=010, SRC0_PCOMP=011, SRC0_PTERM=100; control-word struct.
- Optional sub-module pi_seq_decode: pure state→control-word decode.

Test Plan:
- Reset mid-PCMP (rst_n=0 one edge) → next cycle state IDLE; all registers 0, busy=0, strt_cnv=0.
- go=1, cnv_cmplt after 5 cycles with a2d_res=0xABC; stub ALU dst=0x1111,0x2222,…,0x6666 per op → a2d_val=0x0ABC, Error=0x1111, Intgrl=0x2222, Icomp=0x3333, Pcomp=0x4444, Accum=0x5555, mtr_out=0x6666; done 6 edges after cnv_cmplt; control words match the table in order.
- cnv_cmplt never asserted → tmo_err=1 after 1023 WAIT cycles, busy=0, registers unchanged; next go clears tmo_err.
- go held high throughout and extra cnv_cmplt pulses during compute → exactly one strt_cnv per iteration; no extra writes.
- INTGRL_DECIMATE_EN defined, four iterations with dst=0x0007 in INTG → Intgrl changes only on the 4th iteration; sequence length identical in all four.
- cnv_cmplt asserted on the cycle counter reaches A2D_TMO → sequence proceeds; tmo_err stays 0.
